pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS pipeline. It sits beside the opcode decoder and drives the enables of the PC, IF/ID and later pipeline registers. It inserts load-use bubbles, flushes on taken branches resolved in MEM, and freezes the whole pipe while data memory is not ready. It also gates register writeback during post-reset pipeline fill and keeps saturating stall and flush statistics counters.

Parameters:
FILL_CYCLES, 4, number of advancing cycles after reset during which wb_enable stays low
CNT_W, 16, width of the stall and flush statistics counters

Ports:
clk  in  1  pipeline clock
rst_n  in  1  asynchronous active-low reset
ifid_rs  in  5  rs field of the instruction in IF/ID
ifid_rt  in  5  rt field of the instruction in IF/ID
ifid_uses_rt  in  1  IF/ID instruction reads rt (R-type, BEQ, SW)
idex_memread  in  1  MemRead bit of the ID/EX M bundle
idex_rt  in  5  destination rt of the instruction in ID/EX
exmem_branch  in  1  Branch bit of the EX/MEM M bundle
exmem_zero  in  1  ALU zero flag in EX/MEM
mem_ready  in  1  data memory ready; 0 holds the entire pipe
pc_write  out  1  PC load enable
pc_src  out  1  1 selects branch target
ifid_write  out  1  IF/ID load enable
ifid_flush  out  1  clear IF/ID to NOP
idex_bubble  out  1  force ID/EX EX/M/WB bundles to NOP (4'b0, 3'b0, 2'b0)
exmem_bubble  out  1  force EX/MEM M/WB bundles to NOP
pipe_en  out  1  load enable for ID/EX, EX/MEM and MEM/WB
wb_enable  out  1  qualifies RegWrite at WB
state  out  2  registered controller state
stall_count  out  CNT_W  saturating count of stall cycles
flush_count  out  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Reset (async, rst_n=0): state=FILL, fill counter=0, both statistics counters=0. While rst_n=0, all control outputs are forced to 0, gated combinationally: pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, exmem_bubble, pipe_en, wb_enable.
- Control outputs are combinational from the inputs and the registered state. Zero-cycle latency: an action applies at the next clk edge.
- Load-use hazard (lu) = idex_memread & (idex_rt!=0) & ((idex_rt==ifid_rs) | (ifid_uses_rt & idex_rt==ifid_rt)).
- Branch taken (bt) = exmem_branch & exmem_zero.
- Priority per cycle: HOLD > BRANCH > LOADUSE > NORMAL.
- HOLD (mem_ready=0):
  - pc_write=ifid_write=pipe_en=0; no flush, no bubble, pc_src=0.
  - State is unchanged. The fill counter does not advance. stall_count increments.
  - bt and lu are re-evaluated after release, because the frozen registers keep them true.
- BRANCH (bt):
  - pc_src=1, pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1, exmem_bubble=1, pipe_en=1.
  - next state=FLUSH; flush_count increments.
  - A simultaneous lu is discarded and stall_count does not increment.
- LOADUSE (lu, no bt):
  - pc_write=0, ifid_write=0, idex_bubble=1, pipe_en=1.
  - next state=STALL; stall_count increments.
  - Exactly one bubble is inserted, because the bubble clears idex_memread on the next cycle.
- NORMAL: pc_write=ifid_write=pipe_en=1, all others 0. next state=RUN, or stays FILL until fill completes.
- Fill handling:
  - In FILL, wb_enable=0. The fill counter increments on every cycle with pipe_en=1.
  - When the counter reaches FILL_CYCLES, state becomes RUN from the next cycle.
  - BRANCH or LOADUSE during FILL still act, but state remains FILL until the count completes.
  - In all other states, wb_enable=1.
- State encoding: FILL=0, RUN=1, STALL=2, FLUSH=3. The state register reflects the action taken in the previous cycle.
- Counters saturate at all-ones and never wrap.
- Reset asserted mid-stall or mid-flush returns immediately to FILL with counters cleared.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode constants (RTYPE, LW, SW, BEQ, NOP)
  - EX/M/WB bundle widths (4/3/2) and NOP bundle values
  - M bundle bit indices (Branch=2, MemRead=1, MemWrite=0)
  - state encodings
- One natural sub-module: load_use_detect, a combinational lu comparator reusable by the forwarding unit.

Test Plan:
- Reset release with mem_ready=1 and no hazards -> wb_enable=0 for exactly 4 cycles, then 1; state goes 0 to 1; pc_write=1 throughout.
- ID/EX holds LW with rt=5 and IF/ID holds ADD with rs=5 -> one cycle with pc_write=0, ifid_write=0, idex_bubble=1; next cycle state=2 and pc_write=1; stall_count=1.
- Load-use with idex_rt=0, or match on rt with ifid_uses_rt=0 -> no stall.
- exmem_branch=1, exmem_zero=1 together with a load-use match -> pc_src=1, ifid_flush=idex_bubble=exmem_bubble=1, state=3, flush_count=1, stall_count unchanged.
- mem_ready=0 for 3 cycles during a pending load-use -> pipe_en=0, no bubble, stall_count +3; on release the bubble is inserted once.
- stall_count preset near saturation via repeated stalls with CNT_W=4 -> holds at 15; rst_n pulsed low mid-stall -> outputs 0 immediately, counters 0, state=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control path.
// Holds the opcode constants, the EX/M/WB control bundle widths and their
// NOP values, the M bundle bit positions and the hazard controller's
// state encoding. Ports: none (package).
package ctrl_pkg;

  // Opcode field values (instr[31:26]); NOP is the all-zero SLL encoding.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_NOP   = 6'b000000;

  // Control bundle widths carried through ID/EX and EX/MEM.
  localparam int EX_W = 4;
  localparam int M_W  = 3;
  localparam int WB_W = 2;

  localparam logic [EX_W-1:0] EX_NOP = '0;
  localparam logic [M_W-1:0]  M_NOP  = '0;
  localparam logic [WB_W-1:0] WB_NOP = '0;

  // Bit positions inside the M bundle.
  localparam int M_BRANCH   = 2;
  localparam int M_MEMREAD  = 1;
  localparam int M_MEMWRITE = 0;

  // Controller state; the register reflects the action of the previous cycle.
  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard comparator.
// Flags when the load in ID/EX writes a register that the instruction in
// IF/ID reads. Register 0 is never a hazard since it is hardwired to zero.
// Ports:
//   ifid_rs_i, ifid_rt_i  source fields of the IF/ID instruction
//   ifid_uses_rt_i        IF/ID instruction actually reads rt
//   idex_memread_i        ID/EX instruction is a load
//   idex_rt_i             load destination register
//   lu_o                  load-use hazard present
module load_use_detect (
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  input  logic       ifid_uses_rt_i,
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  output logic       lu_o
);

  assign lu_o = idex_memread_i && (idex_rt_i != 5'd0) &&
                ((idex_rt_i == ifid_rs_i) ||
                 (ifid_uses_rt_i && (idex_rt_i == ifid_rt_i)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS pipeline.
// Per cycle it picks one action, highest priority first:
//   HOLD    (mem_ready=0) freeze everything
//   BRANCH  (taken branch in EX/MEM) redirect PC, flush IF/ID, bubble ID/EX, EX/MEM
//   LOADUSE hold PC and IF/ID, bubble ID/EX
//   NORMAL  advance
// Writeback is gated until FILL_CYCLES advancing cycles after reset.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   ifid_rs/rt/uses_rt, idex_memread/rt  load-use detection inputs
//   exmem_branch, exmem_zero           branch resolution in MEM
//   mem_ready                          data memory ready
//   pc_write, pc_src, ifid_write, ifid_flush, idex_bubble,
//   exmem_bubble, pipe_en, wb_enable   pipeline control (0 while in reset)
//   state                              registered controller state
//   stall_count, flush_count           saturating statistics
module pipe_hazard_ctrl
  import ctrl_pkg::*;
#(
  parameter int FILL_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             pipe_en,
  output logic             wb_enable,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int FW = (FILL_CYCLES < 1) ? 1 : $clog2(FILL_CYCLES + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e           state_q, state_d, act_state;
  logic [FW-1:0]    fill_q, fill_d;
  logic [CNT_W-1:0] stall_q, stall_d, flush_q, flush_d;
  logic             lu, bt;
  logic             pc_write_c, pc_src_c, ifid_write_c, ifid_flush_c;
  logic             idex_bubble_c, exmem_bubble_c, pipe_en_c, wb_enable_c;

  load_use_detect u_lu (
    .ifid_rs_i      (ifid_rs),
    .ifid_rt_i      (ifid_rt),
    .ifid_uses_rt_i (ifid_uses_rt),
    .idex_memread_i (idex_memread),
    .idex_rt_i      (idex_rt),
    .lu_o           (lu)
  );

  assign bt = exmem_branch & exmem_zero;

  always_comb begin
    pc_write_c     = 1'b1;
    pc_src_c       = 1'b0;
    ifid_write_c   = 1'b1;
    ifid_flush_c   = 1'b0;
    idex_bubble_c  = 1'b0;
    exmem_bubble_c = 1'b0;
    pipe_en_c      = 1'b1;
    wb_enable_c    = (state_q != ST_FILL);
    act_state      = ST_RUN;
    state_d        = state_q;
    fill_d         = fill_q;
    stall_d        = stall_q;
    flush_d        = flush_q;

    if (!mem_ready) begin
      // Frozen registers keep bt/lu asserted, so they resolve after release.
      pc_write_c   = 1'b0;
      ifid_write_c = 1'b0;
      pipe_en_c    = 1'b0;
      stall_d      = sat_inc(stall_q);
    end else if (bt) begin
      // Any concurrent load-use belongs to a wrong-path instruction.
      pc_src_c       = 1'b1;
      ifid_flush_c   = 1'b1;
      idex_bubble_c  = 1'b1;
      exmem_bubble_c = 1'b1;
      act_state      = ST_FLUSH;
      flush_d        = sat_inc(flush_q);
    end else if (lu) begin
      pc_write_c    = 1'b0;
      ifid_write_c  = 1'b0;
      idex_bubble_c = 1'b1;
      act_state     = ST_STALL;
      stall_d       = sat_inc(stall_q);
    end

    // Every non-hold cycle advances the back of the pipe and counts toward fill.
    if (mem_ready) begin
      if (state_q == ST_FILL) begin
        if (32'(fill_q) + 32'd1 >= 32'(FILL_CYCLES)) begin
          state_d = act_state;
        end else begin
          fill_d = fill_q + FW'(1);
        end
      end else begin
        state_d = act_state;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FILL;
      fill_q  <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  // Controls are forced low combinationally while reset is asserted.
  assign pc_write     = rst_n & pc_write_c;
  assign pc_src       = rst_n & pc_src_c;
  assign ifid_write   = rst_n & ifid_write_c;
  assign ifid_flush   = rst_n & ifid_flush_c;
  assign idex_bubble  = rst_n & idex_bubble_c;
  assign exmem_bubble = rst_n & exmem_bubble_c;
  assign pipe_en      = rst_n & pipe_en_c;
  assign wb_enable    = rst_n & wb_enable_c;
  assign state        = state_q;
  assign stall_count  = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       ifid_rs, ifid_rt, idex_rt;
  logic             ifid_uses_rt, idex_memread, exmem_branch, exmem_zero, mem_ready;
  logic             pc_write, pc_src, ifid_write, ifid_flush;
  logic             idex_bubble, exmem_bubble, pipe_en, wb_enable;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_count, flush_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.FILL_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .idex_memread (idex_memread),
    .idex_rt      (idex_rt),
    .exmem_branch (exmem_branch),
    .exmem_zero   (exmem_zero),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .pc_src       (pc_src),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .exmem_bubble (exmem_bubble),
    .pipe_en      (pipe_en),
    .wb_enable    (wb_enable),
    .state        (state),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
  );

  // Outputs packed as {pc_write,pc_src,ifid_write,ifid_flush,idex_bubble,exmem_bubble,pipe_en,wb_enable}
  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urt;
    logic       mrd;
    logic [4:0] xrt;
    logic       br;
    logic       z;
    logic       rdy;
    logic [7:0] eo;
    logic [1:0] est;
    int         esc;
    int         efc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                              input logic mrd, input logic [4:0] xrt, input logic br,
                              input logic z, input logic rdy, input logic [7:0] eo,
                              input logic [1:0] est, input int esc, input int efc);
    vec_t v;
    v.rs = rs; v.rt = rt; v.urt = urt; v.mrd = mrd; v.xrt = xrt;
    v.br = br; v.z = z; v.rdy = rdy; v.eo = eo; v.est = est; v.esc = esc; v.efc = efc;
    return v;
  endfunction

  function automatic logic [7:0] outs();
    return {pc_write, pc_src, ifid_write, ifid_flush,
            idex_bubble, exmem_bubble, pipe_en, wb_enable};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    ifid_rs = v.rs; ifid_rt = v.rt; ifid_uses_rt = v.urt;
    idex_memread = v.mrd; idex_rt = v.xrt;
    exmem_branch = v.br; exmem_zero = v.z; mem_ready = v.rdy;
  endtask

  // Inputs change 1ns after posedge, outputs are sampled at negedge.
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check({tag, " outs"},  int'(outs()),        int'(v.eo));
    check({tag, " state"}, int'(state),         int'(v.est));
    check({tag, " stall"}, int'(stall_count),   v.esc);
    check({tag, " flush"}, int'(flush_count),   v.efc);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle, lu5, sv;
    idle = mk(5'd1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 0, 0);
    lu5  = mk(5'd5, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 8'h00, 2'd0, 0, 0);

    // Reset release and fill: wb_enable low for 4 advancing cycles.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 8'b1010_0010, 2'd0, 0, 0));
    tbl.push_back(mk(5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 8'b1010_0011, 2'd1, 0, 0));
    // LW rt=5 in ID/EX, ADD rs=5 in IF/ID: one bubble.
    tbl.push_back(mk(5'd5, 5'd2, 1, 1, 5'd5, 0, 0, 1, 8'b0000_1011, 2'd1, 0, 0));
    tbl.push_back(mk(5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 8'b1010_0011, 2'd2, 1, 0));
    // idex_rt=0 never stalls; rt match without uses_rt does not stall.
    tbl.push_back(mk(5'd0, 5'd0, 1, 1, 5'd0, 0, 0, 1, 8'b1010_0011, 2'd1, 1, 0));
    tbl.push_back(mk(5'd3, 5'd7, 0, 1, 5'd7, 0, 0, 1, 8'b1010_0011, 2'd1, 1, 0));
    tbl.push_back(mk(5'd3, 5'd7, 1, 1, 5'd7, 0, 0, 1, 8'b0000_1011, 2'd1, 1, 0));
    // Taken branch with simultaneous load-use: branch wins.
    tbl.push_back(mk(5'd5, 5'd2, 1, 1, 5'd5, 1, 1, 1, 8'b1111_1111, 2'd2, 2, 0));
    tbl.push_back(mk(5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 8'b1010_0011, 2'd3, 2, 1));
    // Branch not taken.
    tbl.push_back(mk(5'd1, 5'd2, 1, 0, 5'd0, 1, 0, 1, 8'b1010_0011, 2'd1, 2, 1));
    // mem_ready low 3 cycles with a pending load-use, then one bubble.
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(5'd9, 5'd4, 1, 1, 5'd4, 0, 0, 0, 8'b0000_0001, 2'd1, 2 + i, 1));
    tbl.push_back(mk(5'd9, 5'd4, 1, 1, 5'd4, 0, 0, 1, 8'b0000_1011, 2'd1, 5, 1));
    tbl.push_back(mk(5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 8'b1010_0011, 2'd2, 6, 1));
    // Hold with a pending taken branch, then the branch acts on release.
    tbl.push_back(mk(5'd1, 5'd2, 1, 0, 5'd0, 1, 1, 0, 8'b0000_0001, 2'd1, 6, 1));
    tbl.push_back(mk(5'd1, 5'd2, 1, 0, 5'd0, 1, 1, 1, 8'b1111_1111, 2'd1, 7, 1));
    tbl.push_back(mk(5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 8'b1010_0011, 2'd3, 7, 2));

    // Reset state: outputs gated low even with mem_ready=1.
    rst_n = 1'b0;
    drive(idle);
    @(negedge clk);
    check("reset outs",  int'(outs()),      0);
    check("reset state", int'(state),       0);
    check("reset stall", int'(stall_count), 0);
    check("reset flush", int'(flush_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Consecutive load-use stalls drive stall_count into saturation (7+10 -> 15).
    for (int i = 0; i < 10; i++) begin
      drive(lu5);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("sat stall", int'(stall_count), 15);
    check("sat state", int'(state),       2);
    check("sat bubble", int'(idex_bubble), 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("sat hold", int'(stall_count), 15);

    // Reset pulsed mid-stall: immediate effect, away from any edge.
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst outs",  int'(outs()),      0);
    check("midrst state", int'(state),       0);
    check("midrst stall", int'(stall_count), 0);
    check("midrst flush", int'(flush_count), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load-use during fill acts but state stays FILL; it counts as advancing.
    sv = mk(5'd5, 5'd2, 1, 1, 5'd5, 0, 0, 1, 8'b0000_1010, 2'd0, 0, 0);
    apply(sv, "fill_lu");
    for (int i = 0; i < 3; i++) begin
      sv = mk(5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 8'b1010_0010, 2'd0, 1, 0);
      apply(sv, $sformatf("fill%0d", i));
    end
    sv = mk(5'd1, 5'd2, 1, 0, 5'd0, 0, 0, 1, 8'b1010_0011, 2'd1, 1, 0);
    apply(sv, "fill_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
